// File: rtl/dmas_delay_interp_streamer.sv
// Streams one delay-aligned, linearly interpolated RF sample per channel per clock
// into the DMAS core. Per-channel RF memory and delay table are written while idle.
module dmas_delay_interp_streamer #(
  parameter int CHANNELS = 128,
  parameter int SAMPLES  = 1024,
  parameter int DW       = 16,
  parameter int FRAC_W   = 4,
  parameter int IDX_W    = $clog2(SAMPLES),
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_we,
  input  logic [CH_W-1:0]         rf_wch,
  input  logic [IDX_W-1:0]        rf_widx,
  input  logic [DW-1:0]           rf_wdata,
  input  logic                    dly_we,
  input  logic [CH_W-1:0]         dly_wch,
  input  logic [IDX_W+FRAC_W-1:0] dly_wdata,
  input  logic                    start,
  output logic                    busy,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic [DW-1:0]           out_data,
  output logic                    done
);

  localparam int AW = CH_W + IDX_W;
  localparam int PW = DW + 1 + FRAC_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [CH_W-1:0] ch_cnt, ch_cnt_nx;
  logic            issue;
  logic [CH_W-1:0] issue_ch;
  logic            idle;
  logic            done_r;

  logic [DW-1:0]           rf_mem  [2**AW];
  logic [IDX_W+FRAC_W-1:0] dly_mem [CHANNELS];

  assign idle = (state == IDLE);
  assign busy = !idle;
  assign done = done_r;

  always_ff @(posedge clk) begin
    if (idle && rf_we)  rf_mem[{rf_wch, rf_widx}] <= rf_wdata;
    if (idle && dly_we) dly_mem[dly_wch]          <= dly_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch_cnt <= '0;
    end else begin
      state  <= state_nx;
      ch_cnt <= ch_cnt_nx;
    end
  end

  // Channel 0 is issued on the accepting edge itself so the first beat lands
  // four cycles after start; RUN then issues the remaining channels.
  always_comb begin
    state_nx  = state;
    ch_cnt_nx = ch_cnt;
    issue     = 1'b0;
    issue_ch  = ch_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          issue     = 1'b1;
          issue_ch  = '0;
          ch_cnt_nx = CH_W'(1);
          state_nx  = RUN;
        end
      end
      RUN: begin
        issue     = 1'b1;
        ch_cnt_nx = ch_cnt + 1'b1;
        if (ch_cnt == CH_W'(CHANNELS - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (done_r) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pipeline registers
  logic                    v1, f1, l1;
  logic [CH_W-1:0]         c1;
  logic [IDX_W-1:0]        i1;
  logic [FRAC_W-1:0]       fr1;
  logic                    v2, f2, l2;
  logic signed [DW-1:0]    s0_2, s1_2;
  logic [FRAC_W-1:0]       fr2;
  logic                    v3, f3, l3;
  logic signed [DW-1:0]    s0_3;
  logic signed [PW-1:0]    p3;

  logic [IDX_W-1:0]        i1_nx;
  logic signed [DW-1:0]    rd0, rd1;
  logic signed [DW:0]      d;
  logic signed [PW-1:0]    d_ext, fr_ext, prod;
  logic signed [PW:0]      sum;
  logic [DW-1:0]           sat;

  always_comb begin
    i1_nx = i1 + 1'b1;
    rd0   = rf_mem[{c1, i1}];
    rd1   = (i1 == IDX_W'(SAMPLES - 1)) ? rd0 : rf_mem[{c1, i1_nx}];
  end

  always_comb begin
    d      = {s1_2[DW-1], s1_2} - {s0_2[DW-1], s0_2};
    d_ext  = PW'(d);
    fr_ext = PW'($signed({1'b0, fr2}));
    prod   = d_ext * fr_ext;
  end

  always_comb begin
    sum = (PW+1)'(s0_3) + (PW+1)'(p3 >>> FRAC_W);
    if (sum[PW:DW-1] == '0 || sum[PW:DW-1] == '1) sat = sum[DW-1:0];
    else if (sum[PW])                              sat = {1'b1, {(DW-1){1'b0}}};
    else                                           sat = {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; f1 <= 1'b0; l1 <= 1'b0;
      v2 <= 1'b0; f2 <= 1'b0; l2 <= 1'b0;
      v3 <= 1'b0; f3 <= 1'b0; l3 <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done_r    <= 1'b0;
    end else begin
      v1         <= issue;
      f1         <= issue && (issue_ch == '0);
      l1         <= issue && (issue_ch == CH_W'(CHANNELS - 1));
      c1         <= issue_ch;
      {i1, fr1}  <= dly_mem[issue_ch];

      v2   <= v1; f2 <= f1; l2 <= l1;
      s0_2 <= rd0;
      s1_2 <= rd1;
      fr2  <= fr1;

      v3   <= v2; f3 <= f2; l3 <= l2;
      s0_3 <= s0_2;
      p3   <= prod;

      out_valid <= v3;
      out_first <= v3 && f3;
      out_last  <= v3 && l3;
      if (v3) out_data <= sat;
      done_r <= out_valid && out_last;
    end
  end

endmodule

// File: tb/tb_dmas_delay_interp_streamer.sv
// Randomized bench for dmas_delay_interp_streamer against an arithmetic reference
// of the interpolation rule, plus directed boundary, disturbance and reset cases.
module tb_dmas_delay_interp_streamer;

  localparam int CHANNELS = 128;
  localparam int SAMPLES  = 1024;
  localparam int DW       = 16;
  localparam int FRAC_W   = 4;
  localparam int IDX_W    = 10;
  localparam int CH_W     = 7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rf_we = 1'b0;
  logic [CH_W-1:0]         rf_wch = '0;
  logic [IDX_W-1:0]        rf_widx = '0;
  logic [DW-1:0]           rf_wdata = '0;
  logic                    dly_we = 1'b0;
  logic [CH_W-1:0]         dly_wch = '0;
  logic [IDX_W+FRAC_W-1:0] dly_wdata = '0;
  logic                    start = 1'b0;
  logic                    busy, out_valid, out_first, out_last, done;
  logic [DW-1:0]           out_data;

  always #5 clk = ~clk;

  dmas_delay_interp_streamer #(
    .CHANNELS(CHANNELS), .SAMPLES(SAMPLES), .DW(DW),
    .FRAC_W(FRAC_W), .IDX_W(IDX_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rf_we(rf_we), .rf_wch(rf_wch), .rf_widx(rf_widx), .rf_wdata(rf_wdata),
    .dly_we(dly_we), .dly_wch(dly_wch), .dly_wdata(dly_wdata),
    .start(start), .busy(busy), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .out_data(out_data), .done(done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference state: what the DUT memories should hold
  int rf_m [int];
  int dly_idx  [CHANNELS];
  int dly_frac [CHANNELS];

  function automatic int model_out(input int ch);
    int s0, s1, p, q, r;
    s0 = rf_m[ch*SAMPLES + dly_idx[ch]];
    s1 = (dly_idx[ch] == SAMPLES-1) ? s0 : rf_m[ch*SAMPLES + dly_idx[ch] + 1];
    p  = (s1 - s0) * dly_frac[ch];
    q  = p / (1 << FRAC_W);
    if (p < 0 && (p % (1 << FRAC_W)) != 0) q = q - 1;
    r  = s0 + q;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  typedef struct { bit first; bit last; int data; } beat_t;
  beat_t    got_q[$];
  int       done_cnt = 0;
  bit       prev_last = 1'b0;
  bit       mon_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0;
      mon_hold  = 1'b0;
    end else begin
      if (out_valid) begin
        got_q.push_back('{out_first, out_last, int'($signed(out_data))});
      end else begin
        chk("flags_idle", int'({out_first, out_last}), 0);
        if (mon_hold) chk("data_hold", int'(out_data), int'(prev_data));
      end
      if (done || prev_last) chk("done_timing", int'(done), int'(prev_last));
      if (done) done_cnt++;
      prev_last = out_valid && out_last;
      prev_data = out_data;
      mon_hold  = 1'b1;
    end
  end

  task automatic wr_dly(input int ch, input int idx, input int fr);
    @(negedge clk);
    dly_we    = 1'b1;
    dly_wch   = CH_W'(ch);
    dly_wdata = {idx[IDX_W-1:0], fr[FRAC_W-1:0]};
    dly_idx[ch]  = idx;
    dly_frac[ch] = fr;
    @(posedge clk); #1 dly_we = 1'b0;
  endtask

  task automatic wr_rf(input int ch, input int idx, input int val);
    @(negedge clk);
    rf_we    = 1'b1;
    rf_wch   = CH_W'(ch);
    rf_widx  = IDX_W'(idx);
    rf_wdata = val[DW-1:0];
    rf_m[ch*SAMPLES + idx] = val;
    @(posedge clk); #1 rf_we = 1'b0;
  endtask

  task automatic set_ch(input int ch, input int idx, input int fr, input int s0, input int s1);
    wr_dly(ch, idx, fr);
    wr_rf(ch, idx, s0);
    if (idx < SAMPLES-1) wr_rf(ch, idx+1, s1);
  endtask

  function automatic int rnd16();
    case ($urandom_range(0, 3))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic setup_random();
    int idx;
    for (int c = 0; c < CHANNELS; c++) begin
      idx = ($urandom_range(0, 7) == 0) ? SAMPLES-1 : int'($urandom_range(0, SAMPLES-1));
      set_ch(c, idx, int'($urandom_range(0, 15)), rnd16(), rnd16());
    end
    set_ch(0, int'($urandom_range(0, 1022)), 8, 100, 200);
    set_ch(1, int'($urandom_range(0, 1022)), 8, 200, 100);
    set_ch(2, int'($urandom_range(0, 1022)), 1, 0, -1);
    set_ch(3, int'($urandom_range(0, 1022)), 15, -32768, 32767);
    set_ch(4, SAMPLES-1, 9, -77, 0);
  endtask

  // mode: 0 plain, 1 disturb at beat 20, 2 reset at beat 50, 3 leave for back-to-back start
  task automatic run_pixel(input string tag, input int mode);
    int exp_q[$];
    int lat, cyc, n;
    bit disturbed;
    disturbed = 1'b0;
    for (int c = 0; c < CHANNELS; c++) exp_q.push_back(model_out(c));
    @(negedge clk);
    got_q.delete();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);

    if (mode == 2) begin
      cyc = 0;
      while (got_q.size() < 50 && cyc < 200) begin @(negedge clk); cyc++; end
      chk({tag, "_reach50"}, int'(got_q.size() >= 50), 1);
      rst = 1'b1;
      @(negedge clk);
      chk({tag, "_rst_busy"},  int'(busy), 0);
      chk({tag, "_rst_valid"}, int'(out_valid), 0);
      chk({tag, "_rst_first"}, int'(out_first), 0);
      chk({tag, "_rst_last"},  int'(out_last), 0);
      chk({tag, "_rst_done"},  int'(done), 0);
      chk({tag, "_rst_data"},  int'(out_data), 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk({tag, "_rst_nodone"}, done_cnt, 0);
      return;
    end

    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mode == 1 && !disturbed && got_q.size() >= 20) begin
        disturbed = 1'b1;
        start     = 1'b1;
        dly_we    = 1'b1;
        dly_wch   = CH_W'(100);
        dly_wdata = (IDX_W+FRAC_W)'($urandom);
        rf_we     = 1'b1;
        rf_wch    = CH_W'(100);
        rf_widx   = IDX_W'(dly_idx[100]);
        rf_wdata  = DW'(~rf_m[100*SAMPLES + dly_idx[100]]);
      end else begin
        start  = 1'b0;
        dly_we = 1'b0;
        rf_we  = 1'b0;
      end
    end
    start = 1'b0; dly_we = 1'b0; rf_we = 1'b0;
    chk({tag, "_done_seen"}, done_cnt, 1);
    if (mode != 3) begin
      repeat (4) @(negedge clk);
      chk({tag, "_one_done"}, done_cnt, 1);
      chk({tag, "_idle"}, int'(busy), 0);
    end

    chk({tag, "_beats"}, got_q.size(), CHANNELS);
    n = (got_q.size() < CHANNELS) ? got_q.size() : CHANNELS;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i),  got_q[i].data, exp_q[i]);
      chk($sformatf("%s_first%0d", tag, i), int'(got_q[i].first), int'(i == 0));
      chk($sformatf("%s_last%0d", tag, i),  int'(got_q[i].last), int'(i == CHANNELS-1));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_first", int'(out_first), 0);
    chk("rst_last",  int'(out_last), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_data",  int'(out_data), 0);
    rst = 1'b0;

    for (int c = 0; c < CHANNELS; c++) begin
      set_ch(c, 5, 0, c*10, rnd16());
    end
    run_pixel("t1", 0);

    setup_random();
    run_pixel("t2", 0);

    setup_random();
    run_pixel("t5", 1);
    run_pixel("t5b", 0);

    setup_random();
    run_pixel("t6", 2);
    run_pixel("t6b", 0);

    run_pixel("bb1", 3);
    run_pixel("bb2", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
